// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the SDRAM controller arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ISSUE,
    WAIT_CPLT
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_gnt, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   sel;

  // Bit 0 of rot is the requester just after last_gnt; the lowest set bit wins.
  always_comb begin
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> (int'(last_gnt) + 1));
    valid = 1'b0;
    sel   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        sel   = int'(last_gnt) + 1 + k;
      end
    end
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    idx = $clog2(NUM_REQ)'(sel);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem_cntrl among NUM_REQ hold-until-ack requesters,
// one transaction in flight, with a sticky completion timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 3,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_data_in,
  output logic                           mem_r_en,
  output logic                           mem_w_en,
  input  logic [DATA_WIDTH-1:0]          mem_data_out,
  input  logic                           mem_rdy,
  input  logic                           mem_cplt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner, last_gnt, pick_idx;
  logic             pick_valid;
  logic             own_we;
  logic [CNT_W-1:0] wait_cnt;
  logic             start, done, expire;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Never issue while mem_cplt is high, so mem_cntrl is not re-strobed mid-handshake.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid && mem_rdy && !mem_cplt) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_CPLT;
      WAIT_CPLT: begin
        if (mem_cplt) begin
          done      = 1'b1;
          state_nxt = ARB_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
          expire    = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      owner       <= '0;
      last_gnt    <= IDX_W'(NUM_REQ - 1);
      own_we      <= 1'b0;
      wait_cnt    <= '0;
      ack         <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != ARB_IDLE);
      ack      <= '0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;

      if (start) begin
        owner       <= pick_idx;
        own_we      <= req_we[pick_idx];
        mem_addr    <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data_in <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
        mem_w_en    <= req_we[pick_idx];
        mem_r_en    <= !req_we[pick_idx];
      end

      // Saturating wait counter; restarts every time a strobe goes out.
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT_CPLT && wait_cnt != CNT_W'(TIMEOUT)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (done) begin
        rdata      <= own_we ? '0 : mem_data_out;
        ack[owner] <= 1'b1;
        last_gnt   <= owner;
      end

      if (expire) begin
        timeout_err <= 1'b1;
        rdata       <= '0;
        ack[owner]  <= 1'b1;
        last_gnt    <= owner;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: mem_cntrl stub with programmable completion delay and refresh,
// transaction-level round-robin/scoreboard model, directed scenarios plus a random phase.
module tb_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int NR = 3;
  localparam int TMO = 1023;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   ack;
  logic [DW-1:0]   rdata;
  logic            busy, timeout_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_in;
  logic            mem_r_en, mem_w_en;
  logic [DW-1:0]   mem_data_out;
  logic            mem_rdy, mem_cplt;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy),
    .timeout_err(timeout_err), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_data_out(mem_data_out),
    .mem_rdy(mem_rdy), .mem_cplt(mem_cplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // mem_cntrl stub state
  logic [DW-1:0] mem_model [16];
  bit            st_pend, st_we, hang, refresh_arm;
  int            st_cnt, cplt_delay, refresh_left, refresh_len;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wd;

  // reference model state
  int            m_last, m_owner, m_strobe_cyc, last_ack_cyc;
  bit            m_out, m_we, m_terr;
  logic [DW-1:0] m_rdata_exp;
  int            strobes, acks;
  int            ack_log[$];
  bit            keep[NR];
  bit            rand_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_expect(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic set_txn(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_txn(input int i);
    set_txn(i, 1'($urandom), {20'($urandom), 4'($urandom)}, 16'($urandom));
  endtask

  // One clock: observe DUT after the edge, update model, then drive stub and requesters.
  task automatic tick();
    logic [NR-1:0] r_seen;
    logic c_seen, rdy_seen;
    bit strobe_now, due, tmo;
    int eo;
    r_seen = req; c_seen = mem_cplt; rdy_seen = mem_rdy;
    @(posedge clk); #1; cyc++;

    strobe_now = mem_r_en || mem_w_en;
    if (strobe_now) begin
      strobes++;
      eo = rr_expect(r_seen, m_last);
      chk("strobe_while_busy", m_out, 1'b0);
      chk("strobe_in_cplt", c_seen, 1'b0);
      chk("strobe_not_rdy", rdy_seen, 1'b1);
      chk("strobe_no_req", eo >= 0, 1'b1);
      if (eo >= 0) begin
        chk("strobe_addr", mem_addr, req_addr[eo*AW +: AW]);
        chk("strobe_rw", {mem_w_en, mem_r_en}, req_we[eo] ? 2'b10 : 2'b01);
        if (req_we[eo]) chk("strobe_wdata", mem_data_in, req_wdata[eo*DW +: DW]);
        m_owner = eo; m_out = 1'b1; m_strobe_cyc = cyc; m_we = req_we[eo];
        st_pend = 1'b1; st_we = mem_w_en; st_addr = mem_addr; st_wd = mem_data_in;
        st_cnt = rand_mode ? int'($urandom_range(1, 6)) : cplt_delay;
        if (refresh_arm) begin refresh_left = refresh_len; refresh_arm = 1'b0; end
      end
    end

    due = m_out && !strobe_now && (c_seen || (cyc - m_strobe_cyc == TMO + 2));
    if (due || ack != '0) begin
      chk("ack_vec", ack, due ? 3'(1 << m_owner) : 3'b000);
      if (due) begin
        tmo = !c_seen;
        chk("ack_rdata", rdata, (tmo || m_we) ? 16'h0 : m_rdata_exp);
        if (tmo) begin m_terr = 1'b1; st_pend = 1'b0; end
        m_last = m_owner; m_out = 1'b0; acks++; last_ack_cyc = cyc;
        ack_log.push_back(m_owner);
        if (rand_mode ? bit'($urandom_range(0, 1)) : keep[m_owner]) rand_txn(m_owner);
        else req[m_owner] = 1'b0;
      end
    end
    chk("busy", busy, m_out);
    chk("timeout_err", timeout_err, m_terr);

    mem_cplt = 1'b0;
    if (refresh_left > 0) refresh_left--;
    if (rand_mode && refresh_left == 0 && $urandom_range(0, 15) == 0)
      refresh_left = $urandom_range(2, 8);
    mem_rdy = (refresh_left == 0);
    if (st_pend && !hang && refresh_left == 0 && !strobe_now) begin
      if (st_cnt <= 1) begin
        st_pend = 1'b0; mem_cplt = 1'b1;
        if (st_we) begin
          mem_model[st_addr[3:0]] = st_wd;
          mem_data_out = 16'($urandom);
          m_rdata_exp = '0;
        end else begin
          mem_data_out = mem_model[st_addr[3:0]];
          m_rdata_exp = mem_data_out;
        end
      end else st_cnt--;
    end

    if (rand_mode)
      for (int i = 0; i < NR; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) rand_txn(i);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mem_cplt = 1'b0; mem_rdy = 1'b1;
    st_pend = 1'b0; refresh_left = 0; refresh_arm = 1'b0; hang = 1'b0;
    for (int i = 0; i < NR; i++) keep[i] = 1'b0;
    @(posedge clk); #1; cyc++;
    chk("rst_ack", ack, 3'b000);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 24'h0);
    chk("rst_mem_data_in", mem_data_in, 16'h0);
    chk("rst_strobes", {mem_r_en, mem_w_en}, 2'b00);
    rst = 1'b0;
    m_last = NR - 1; m_out = 1'b0; m_terr = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int target, t;
    target = acks + n; t = 0;
    while (acks < target && t < budget) begin tick(); t++; end
    chk(tag, acks >= target, 1'b1);
  endtask

  task automatic wait_strobe(input int budget, input string tag);
    int target, t;
    target = strobes + 1; t = 0;
    while (strobes < target && t < budget) begin tick(); t++; end
    chk(tag, strobes >= target, 1'b1);
  endtask

  task automatic drain(input int budget, input string tag);
    int t;
    t = 0;
    while ((req != '0 || m_out) && t < budget) begin tick(); t++; end
    chk(tag, (req == '0) && !m_out, 1'b1);
  endtask

  initial begin
    int s0, n, ts;
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_data_out = '0; mem_rdy = 1'b1; mem_cplt = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = 16'($urandom);
    cplt_delay = 8; refresh_len = 20; rand_mode = 1'b0;
    strobes = 0; acks = 0; m_rdata_exp = '0; m_we = 1'b0; m_owner = 0;
    m_strobe_cyc = 0; last_ack_cyc = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // single read
    mem_model[3] = 16'hBEEF;
    s0 = strobes;
    set_txn(0, 1'b0, 24'h000123, 16'h0);
    wait_acks(1, 40, "single_wait");
    chk("single_strobes", strobes - s0, 1);
    chk("single_owner", ack_log[$], 0);
    chk("single_rdata", rdata, 16'hBEEF);
    drain(10, "single_drain");

    // round-robin with all three writing back-to-back
    do_reset();
    cplt_delay = 2;
    n = ack_log.size(); s0 = strobes;
    for (int i = 0; i < NR; i++) begin keep[i] = 1'b1; set_txn(i, 1'b1, 24'(i), 16'($urandom)); end
    wait_acks(6, 100, "rr_wait");
    for (int i = 0; i < NR; i++) keep[i] = 1'b0;
    for (int k = 0; k < 6; k++) chk("rr_order", ack_log[n + k], k % NR);
    drain(60, "rr_drain");
    chk("rr_strobes", strobes - s0, acks - n);

    // strobe coincides with refresh start
    refresh_arm = 1'b1; cplt_delay = 3; s0 = strobes;
    set_txn(1, 1'b1, 24'h000045, 16'h1234);
    wait_acks(1, 60, "refresh_wr_wait");
    chk("refresh_strobes", strobes - s0, 1);
    set_txn(1, 1'b0, 24'h000045, 16'h0);
    wait_acks(1, 40, "refresh_rd_wait");
    chk("refresh_rdata", rdata, 16'h1234);
    drain(10, "refresh_drain");

    // back-to-back: req0 stays high, req1 arrives while busy
    cplt_delay = 3; keep[0] = 1'b1;
    set_txn(0, 1'b0, 24'h000007, 16'h0);
    wait_strobe(20, "b2b_strobe");
    set_txn(1, 1'b1, 24'h000008, 16'hA5A5);
    wait_acks(2, 60, "b2b_wait");
    keep[0] = 1'b0;
    n = ack_log.size();
    chk("b2b_first", ack_log[n - 2], 0);
    chk("b2b_second", ack_log[n - 1], 1);
    wait_acks(1, 40, "b2b_third");
    chk("b2b_third_owner", ack_log[$], 0);
    drain(20, "b2b_drain");

    // completion never arrives
    hang = 1'b1;
    set_txn(2, 1'b0, 24'h00000A, 16'h0);
    wait_strobe(20, "tmo_strobe");
    ts = m_strobe_cyc;
    wait_acks(1, 1100, "tmo_wait");
    chk("tmo_latency", last_ack_cyc - ts, TMO + 2);
    chk("tmo_err_set", timeout_err, 1'b1);
    hang = 1'b0; cplt_delay = 2;
    set_txn(0, 1'b1, 24'h00000B, 16'h5A5A);
    wait_acks(1, 40, "tmo_next_wait");
    chk("tmo_err_sticky", timeout_err, 1'b1);
    drain(10, "tmo_drain");

    // random traffic with refreshes
    do_reset();
    rand_mode = 1'b1;
    n = acks;
    repeat (400) tick();
    rand_mode = 1'b0;
    drain(300, "rand_drain");
    chk("rand_progress", acks - n > 20, 1'b1);

    // reset in the middle of WAIT_CPLT
    cplt_delay = 50;
    set_txn(2, 1'b0, 24'h00000C, 16'h0);
    wait_strobe(20, "rstmid_strobe");
    repeat (3) tick();
    set_txn(1, 1'b0, 24'h00000D, 16'h0);
    do_reset();
    cplt_delay = 2;
    for (int i = 0; i < NR; i++) set_txn(i, 1'b0, 24'(16 + i), 16'h0);
    wait_acks(1, 40, "rstmid_wait");
    chk("rstmid_first_grant", ack_log[$], 0);
    drain(40, "rstmid_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
